ger_imm_pipe: RTL and testbench
===============================

# ger_imm_pipe

Registered, parametrised immediate generator for the pipelined datapath, sitting between the IF/ID register and the ID/EX stage. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount) to a sign- or zero-extended XLEN-wide value and precomputes the PC-relative target. It flags illegal opcodes. A two-entry skid buffer with valid/ready handshakes on both sides breaks the ready path, and a flush input supports branch recovery.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- iCLK  in  1  clock, rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iValid  in  1  upstream has an instruction.
- oReady  out  1  block can accept; registered.
- iInst  in  32  instruction word.
- iPC  in  XLEN  PC of iInst.
- iFlush  in  1  discard all held and incoming entries.
- oValid  out  1  output entry valid.
- iReady  in  1  downstream accepts.
- oImm  out  XLEN  decoded immediate.
- oFmt  out  3  format code (see package).
- oTarget  out  XLEN  oPC + oImm, modulo 2^XLEN.
- oInst  out  32  instruction passed through.
- oPC  out  XLEN  PC passed through.
- oIllegal  out  1  opcode not recognised.

## Operation
- Input transfer: iValid & oReady at the rising edge. Output transfer: oValid & iReady at the rising edge.
- Decode is combinational on the input side. The register stores {inst, pc, imm, fmt, target, illegal}.
- Format codes:
  - 0 NONE: R-type (0110011, 0111011), FENCE, or illegal; imm = 0.
  - 1 I: LOAD 0000011, OP-IMM 0010011 (except shifts), JALR 1100111, SYSTEM 1110011, OP-IMM-32 0011011 (XLEN=64 only); imm = sext(inst[31:20]).
  - 2 S: 0100011; imm = sext({inst[31:25], inst[11:7]}).
  - 3 B: 1100011; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 4 U: LUI 0110111, AUIPC 0010111; imm = sext({inst[31:12], 12'b0}).
  - 5 J: 1101111; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 6 SHAMT: OP-IMM with funct3 001 or 101; imm = zext(inst[24:20]) when XLEN=32, zext(inst[25:20]) when XLEN=64. funct7 bits are never part of imm.
- Illegal cases set oIllegal = 1, fmt = NONE, imm = 0:
  - inst[1:0] != 2'b11;
  - any opcode not listed above;
  - 0011011 when XLEN=32.
- oTarget = oPC + oImm is always computed. Consumers use it only for B, J, and AUIPC.
- Skid FSM states:
  - EMPTY: 0 entries; oValid = 0.
  - ONE: main entry valid.
  - TWO: main and skid entries valid.
- Transitions:
  - EMPTY→ONE on input transfer.
  - ONE→TWO on input transfer without output transfer.
  - ONE→EMPTY on output transfer without input transfer.
  - ONE stays ONE on simultaneous input and output transfer; the new entry replaces main.
  - TWO→ONE on output transfer; skid moves to main. No input is accepted in TWO.
- oReady next = (next state != TWO).
- Flush: at the edge where iFlush = 1, the state goes to EMPTY. Any same-cycle input transfer is dropped, and any same-cycle output transfer still counts as completed downstream. oReady is 1 next cycle.
- Ordering is strictly FIFO. No entry is duplicated or lost absent a flush.

## Timing
- Latency: 1 cycle from input transfer to oValid, when the block was EMPTY.
- Throughput: 1 entry/cycle with iReady held high.
- Reset (async, immediate): state EMPTY; oValid = 0; oReady = 0. oImm, oFmt, oTarget, oInst, oPC, and oIllegal are all 0.
- oReady rises at the first rising edge with iRST low.
- Reset asserted mid-operation discards both entries at once, with no handshake completion.
- Output payload is stable while oValid & !iReady.
- oReady depends only on registers. There is no combinational path from iReady to oReady.

## Structure
- Package ger_imm_pkg: fmt_t enum (NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6), opcode localparams, and the skid state enum.
- Sub-module ger_imm_decode: purely combinational. Parameter XLEN; inputs inst; outputs imm, fmt, illegal. It is reused by the future decompressor path.
- ger_imm_pipe: instantiates ger_imm_decode, the target adder, and the skid FSM with its two payload registers.

## Test plan
- XLEN=32, 0xFE000EE3 (beq, PC 0x100) → oFmt=3, oImm=0xFFFFFFFC, oTarget=0x000000FC one cycle later.
- 0x001000EF (jal x1, PC 0x0) → oFmt=5, oImm=0x00000800, oTarget=0x800. 0xFE21AFA3 (sw) → oFmt=2, oImm=0xFFFFFFFF.
- 0x4030D093 (srai) → oFmt=6, oImm=3. XLEN=64 with 0x800002B7 (lui) → oImm=0xFFFFFFFF80000000. XLEN=32 with 0x0000001B → oIllegal=1, oImm=0.
- Backpressure, part 1: iReady=0, push A, B, C back-to-back → A and B accepted, oReady=0 from the cycle after B is accepted, C held upstream.
- Backpressure, part 2: then iReady=1 → outputs A, B, C in order, one per cycle, with oReady re-asserting.
- Flush in state TWO with iValid=1 → next cycle oValid=0, oReady=1, and the incoming and held entries never appear. Reset asserted mid-stream → all outputs 0 immediately; oReady=1 one edge after release.

Source files
------------

// File: rtl/ger_imm_pkg.sv
// Shared types for the immediate generator: format codes, opcodes and skid buffer states.
package ger_imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_t;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ger_imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: format classification, extension and illegal-opcode flag.
module ger_imm_decode
    import ger_imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic [6:0]         opcode;
    logic signed [11:0] raw_i;
    logic signed [11:0] raw_s;
    logic signed [12:0] raw_b;
    logic signed [31:0] raw_u;
    logic signed [20:0] raw_j;

    assign opcode = inst[6:0];
    assign raw_i  = inst[31:20];
    assign raw_s  = {inst[31:25], inst[11:7]};
    assign raw_b  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign raw_u  = {inst[31:12], 12'b0};
    assign raw_j  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Format classification; anything unrecognised collapses to NONE with illegal set.
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_OP, OP_OP_32, OP_MISC_MEM: fmt = FMT_NONE;
                OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
                OP_IMM:    fmt = (inst[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
                OP_IMM_32: begin
                    if (XLEN == 64) fmt = FMT_I;
                    else            illegal = 1'b1;
                end
                OP_STORE:          fmt = FMT_S;
                OP_BRANCH:         fmt = FMT_B;
                OP_LUI, OP_AUIPC:  fmt = FMT_U;
                OP_JAL:            fmt = FMT_J;
                default:           illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:     imm = XLEN'(raw_i);
            FMT_S:     imm = XLEN'(raw_s);
            FMT_B:     imm = XLEN'(raw_b);
            FMT_U:     imm = XLEN'(raw_u);
            FMT_J:     imm = XLEN'(raw_j);
            FMT_SHAMT: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/ger_imm_pipe.sv
// Registered immediate generator stage: decode + PC-relative target, behind a two-entry skid buffer.
module ger_imm_pipe
    import ger_imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iInst,
    input  logic [XLEN-1:0] iPC,
    input  logic            iFlush,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oImm,
    output logic [2:0]      oFmt,
    output logic [XLEN-1:0] oTarget,
    output logic [31:0]     oInst,
    output logic [XLEN-1:0] oPC,
    output logic            oIllegal
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry;
    entry_t          main_q;
    entry_t          skid_q;
    skid_state_t     state_q;
    skid_state_t     state_n;
    logic            ready_q;
    logic            valid_q;
    logic            in_xfer;
    logic            out_xfer;
    logic            load_main;
    logic            load_skid;
    logic            shift_skid;

    ger_imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (iInst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        in_entry         = '0;
        in_entry.inst    = iInst;
        in_entry.pc      = iPC;
        in_entry.imm     = dec_imm;
        in_entry.fmt     = dec_fmt;
        in_entry.target  = iPC + dec_imm;
        in_entry.illegal = dec_illegal;
    end

    assign in_xfer  = iValid & ready_q;
    assign out_xfer = valid_q & iReady;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_q <= SKID_EMPTY;
        else      state_q <= state_n;
    end

    // Next state and payload steering; flush overrides everything and drops any incoming entry.
    always_comb begin
        state_n    = state_q;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    state_n   = SKID_ONE;
                    load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    state_n   = SKID_TWO;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_n = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (out_xfer) begin
                    state_n    = SKID_ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_n = SKID_EMPTY;
        endcase
        if (iFlush) begin
            state_n    = SKID_EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            shift_skid = 1'b0;
        end
    end

    // Ready and valid are registered copies of the next state, so iReady never reaches oReady combinationally.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ready_q <= (state_n != SKID_TWO);
            valid_q <= (state_n != SKID_EMPTY);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)       main_q <= in_entry;
            else if (shift_skid) main_q <= skid_q;
            if (load_skid)       skid_q <= in_entry;
        end
    end

    assign oReady   = ready_q;
    assign oValid   = valid_q;
    assign oImm     = main_q.imm;
    assign oFmt     = main_q.fmt;
    assign oTarget  = main_q.target;
    assign oInst    = main_q.inst;
    assign oPC      = main_q.pc;
    assign oIllegal = main_q.illegal;

endmodule

// File: tb/tb_ger_imm_pipe.sv
// Bench for ger_imm_pipe: queue-based reference model checked every cycle, plus directed literal checks.
module tb_ger_imm_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] inst_in = '0;
    logic [31:0] pc_in = '0;
    logic        rdy, ov, ill;
    logic [31:0] imm, tgt, oinst, opc;
    logic [2:0]  fmt;

    logic        v64 = 1'b0;
    logic        r64in = 1'b0;
    logic [31:0] inst64 = '0;
    logic [63:0] pc64 = '0;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64, tgt64, opc64;
    logic [31:0] oinst64;
    logic [2:0]  fmt64;

    int vectors = 0;
    int miscompares = 0;

    ger_imm_pipe #(.XLEN(32)) dut32 (
        .iCLK(clk), .iRST(rst), .iValid(valid_in), .oReady(rdy), .iInst(inst_in), .iPC(pc_in),
        .iFlush(flush), .oValid(ov), .iReady(ready_in), .oImm(imm), .oFmt(fmt), .oTarget(tgt),
        .oInst(oinst), .oPC(opc), .oIllegal(ill)
    );

    ger_imm_pipe #(.XLEN(64)) dut64 (
        .iCLK(clk), .iRST(rst), .iValid(v64), .oReady(rdy64), .iInst(inst64), .iPC(pc64),
        .iFlush(1'b0), .oValid(ov64), .iReady(r64in), .oImm(imm64), .oFmt(fmt64), .oTarget(tgt64),
        .oInst(oinst64), .oPC(opc64), .oIllegal(ill64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the format table using whole-word shifts and masks (XLEN=32).
    function automatic void ref_dec(input logic [31:0] i, output logic [2:0] f,
                                    output logic [31:0] v, output logic bad);
        logic signed [31:0] s20, s19, s11;
        s20 = $signed(i) >>> 20;
        s19 = $signed(i) >>> 19;
        s11 = $signed(i) >>> 11;
        f = 3'd0; v = 32'd0; bad = 1'b0;
        if (i[1:0] != 2'b11) bad = 1'b1;
        else case (i[6:0])
            7'b0110011, 7'b0111011, 7'b0001111: f = 3'd0;
            7'b0000011, 7'b1100111, 7'b1110011: begin f = 3'd1; v = s20; end
            7'b0010011: begin
                if (i[13:12] == 2'b01) begin f = 3'd6; v = (i >> 20) & 32'h1F; end
                else begin f = 3'd1; v = s20; end
            end
            7'b0100011: begin f = 3'd2; v = (s20 & 32'hFFFF_FFE0) | ((i >> 7) & 32'h1F); end
            7'b1100011: begin
                f = 3'd3;
                v = (s19 & 32'hFFFF_F000) | ((i << 4) & 32'h800) | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
            end
            7'b0110111, 7'b0010111: begin f = 3'd4; v = i & 32'hFFFF_F000; end
            7'b1101111: begin
                f = 3'd5;
                v = (s11 & 32'hFFF0_0000) | (i & 32'h000F_F000) | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
            end
            default: bad = 1'b1;
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] target;
        logic [2:0]  fmt;
        logic        bad;
    } exp_t;

    exp_t q[$];
    bit   ready_m = 1'b0;

    // Model: a FIFO of at most two entries; ready means room for another.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            ready_m = 1'b0;
        end else begin
            bit in_x, out_x;
            exp_t e;
            in_x  = valid_in && ready_m;
            out_x = (q.size() > 0) && ready_in;
            if (out_x) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_x) begin
                e.inst = inst_in;
                e.pc   = pc_in;
                ref_dec(inst_in, e.fmt, e.imm, e.bad);
                e.target = pc_in + e.imm;
                q.push_back(e);
            end
            ready_m = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 64'(ov), 64'(q.size() > 0));
        chk("m_ready", 64'(rdy), 64'(ready_m));
        if (q.size() > 0) begin
            chk("m_inst", 64'(oinst), 64'(q[0].inst));
            chk("m_pc", 64'(opc), 64'(q[0].pc));
            chk("m_imm", 64'(imm), 64'(q[0].imm));
            chk("m_fmt", 64'(fmt), 64'(q[0].fmt));
            chk("m_target", 64'(tgt), 64'(q[0].target));
            chk("m_illegal", 64'(ill), 64'(q[0].bad));
        end
    end

    task automatic send(input string nm, input logic [31:0] i, input logic [31:0] p,
                        input logic [2:0] ef, input logic [31:0] eimm, input logic [31:0] etgt,
                        input logic ebad);
        @(posedge clk); #1;
        valid_in = 1'b1; inst_in = i; pc_in = p;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 64'(ov), 64'd1);
        chk({nm, "_fmt"}, 64'(fmt), 64'(ef));
        chk({nm, "_imm"}, 64'(imm), 64'(eimm));
        chk({nm, "_target"}, 64'(tgt), 64'(etgt));
        chk({nm, "_illegal"}, 64'(ill), 64'(ebad));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 64'(ov), 64'd0);
        chk({nm, "_ready"}, 64'(rdy), 64'd0);
        chk({nm, "_imm"}, 64'(imm), 64'd0);
        chk({nm, "_fmt"}, 64'(fmt), 64'd0);
        chk({nm, "_target"}, 64'(tgt), 64'd0);
        chk({nm, "_inst"}, 64'(oinst), 64'd0);
        chk({nm, "_pc"}, 64'(opc), 64'd0);
        chk({nm, "_illegal"}, 64'(ill), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, c;
        a = 32'h0010_0093; b = 32'h0020_0113; c = 32'h0030_0193;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0; ready_in = 1'b1; r64in = 1'b1;
        @(negedge clk); chk("ready_pre_edge", 64'(rdy), 64'd0);
        @(negedge clk); chk("ready_post_edge", 64'(rdy), 64'd1);

        // XLEN=64 instance: lui sign-extends to 64 bits, OP-IMM-32 is legal I-type
        @(posedge clk); #1; v64 = 1'b1; inst64 = 32'h8000_02B7; pc64 = 64'd0;
        @(posedge clk); #1; inst64 = 32'h0000_001B; pc64 = 64'h100;
        @(negedge clk);
        chk("x64_lui_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_fmt", 64'(fmt64), 64'd4);
        chk("x64_lui_valid", 64'(ov64), 64'd1);
        @(posedge clk); #1; v64 = 1'b0;
        @(negedge clk);
        chk("x64_iw_fmt", 64'(fmt64), 64'd1);
        chk("x64_iw_illegal", 64'(ill64), 64'd0);
        chk("x64_iw_target", tgt64, 64'h100);

        send("beq",   32'hFE00_0EE3, 32'h100,  3'd3, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0);
        send("jal",   32'h0010_00EF, 32'h0,    3'd5, 32'h0000_0800, 32'h0000_0800, 1'b0);
        send("sw",    32'hFE21_AFA3, 32'h200,  3'd2, 32'hFFFF_FFFF, 32'h0000_01FF, 1'b0);
        send("srai",  32'h4030_D093, 32'h10,   3'd6, 32'h3,         32'h13,        1'b0);
        send("slli",  32'h01F0_9093, 32'h0,    3'd6, 32'h1F,        32'h1F,        1'b0);
        send("iw32",  32'h0000_001B, 32'h20,   3'd0, 32'h0,         32'h20,        1'b1);
        send("lowbit",32'h00A0_0010, 32'h40,   3'd0, 32'h0,         32'h40,        1'b1);
        send("lui",   32'h8000_02B7, 32'h4,    3'd4, 32'h8000_0000, 32'h8000_0004, 1'b0);
        send("addi",  32'hFFF0_0093, 32'h0,    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send("auipc", 32'h0000_1017, 32'h1000, 3'd4, 32'h1000,      32'h2000,      1'b0);
        send("add",   32'h0020_81B3, 32'h8,    3'd0, 32'h0,         32'h8,         1'b0);

        // Backpressure: A and B fill the buffer, C waits upstream, then drains in order
        @(posedge clk); #1; ready_in = 1'b0; valid_in = 1'b1; inst_in = a; pc_in = 32'h300;
        @(posedge clk); #1; inst_in = b; pc_in = 32'h304;
        @(negedge clk); chk("bp_ready_a", 64'(rdy), 64'd1); chk("bp_inst_a", 64'(oinst), 64'(a));
        @(posedge clk); #1; inst_in = c; pc_in = 32'h308;
        @(negedge clk); chk("bp_ready_full", 64'(rdy), 64'd0); chk("bp_hold_a", 64'(oinst), 64'(a));
        @(posedge clk); #1; ready_in = 1'b1;
        @(negedge clk); chk("bp_stable_a", 64'(oinst), 64'(a)); chk("bp_still_full", 64'(rdy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_out_b", 64'(oinst), 64'(b)); chk("bp_ready_back", 64'(rdy), 64'd1);
        @(posedge clk); #1; valid_in = 1'b0;
        @(negedge clk); chk("bp_out_c", 64'(oinst), 64'(c)); chk("bp_valid_c", 64'(ov), 64'd1);
        @(negedge clk); chk("bp_drained", 64'(ov), 64'd0);

        // Flush while full with a new entry offered
        @(posedge clk); #1; ready_in = 1'b0; valid_in = 1'b1; inst_in = 32'h0040_0213; pc_in = 32'h400;
        @(posedge clk); #1; inst_in = 32'h0050_0293; pc_in = 32'h404;
        @(posedge clk); #1; inst_in = 32'h0060_0313; pc_in = 32'h408; flush = 1'b1;
        @(negedge clk); chk("fl_pre_valid", 64'(ov), 64'd1); chk("fl_pre_ready", 64'(rdy), 64'd0);
        @(posedge clk); #1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk); chk("fl_valid", 64'(ov), 64'd0); chk("fl_ready", 64'(rdy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("fl_quiet", 64'(ov), 64'd0);
        end

        // Reset in the middle of a full buffer
        @(posedge clk); #1; ready_in = 1'b0; valid_in = 1'b1; inst_in = 32'h0070_0393; pc_in = 32'h500;
        @(posedge clk); #1; inst_in = 32'h0080_0413; pc_in = 32'h504;
        @(posedge clk); #1; valid_in = 1'b0;
        @(posedge clk); #3; rst = 1'b1;
        #1; chk_zero("midrst");
        @(posedge clk); #1; rst = 1'b0; ready_in = 1'b1;
        @(negedge clk); chk("midrst_ready_pre", 64'(rdy), 64'd0);
        @(negedge clk); chk("midrst_ready_post", 64'(rdy), 64'd1);

        // Full-rate stream with iReady held high
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            valid_in = 1'b1; inst_in = 32'h0000_0063 | (32'(k) << 8); pc_in = 32'h600 + 32'(k) * 4;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
